// File: rtl/mreq_pkt_tx_if.sv
// mreq_pkt_tx_if
//   Bundles the three handshakes of the MREQ packet transmitter:
//     - byte stream to the Tx FIFO   : o_tx_data, o_tx_valid, i_tx_ready
//     - MREQ request from arbiter    : i_mreq_valid, o_mreq_ready, i_mreq_wr,
//                                      i_mreq_wsize, i_mreq_aincr, i_mreq_size,
//                                      i_mreq_addr
//     - write payload words          : i_wdata, i_wdata_valid, o_wdata_ready
//   Signal names keep the transmitter's point of view (i_ = into it, o_ = out of it).
//   modport slave  : the transmitter itself.
//   modport master : the surrounding logic (arbiter, payload source and byte sink).
interface mreq_pkt_tx_if #(
  parameter int ADDR_BYTES = 4,
  parameter int WORD_BYTES = 4
);
  logic [7:0]              o_tx_data;
  logic                    o_tx_valid;
  logic                    i_tx_ready;
  logic                    i_mreq_valid;
  logic                    o_mreq_ready;
  logic                    i_mreq_wr;
  logic [1:0]              i_mreq_wsize;
  logic                    i_mreq_aincr;
  logic [7:0]              i_mreq_size;
  logic [8*ADDR_BYTES-1:0] i_mreq_addr;
  logic [8*WORD_BYTES-1:0] i_wdata;
  logic                    i_wdata_valid;
  logic                    o_wdata_ready;

  modport slave (
    output o_tx_data, o_tx_valid, o_mreq_ready, o_wdata_ready,
    input  i_tx_ready, i_mreq_valid, i_mreq_wr, i_mreq_wsize, i_mreq_aincr,
           i_mreq_size, i_mreq_addr, i_wdata, i_wdata_valid
  );

  modport master (
    input  o_tx_data, o_tx_valid, o_mreq_ready, o_wdata_ready,
    output i_tx_ready, i_mreq_valid, i_mreq_wr, i_mreq_wsize, i_mreq_aincr,
           i_mreq_size, i_mreq_addr, i_wdata, i_wdata_valid
  );
endinterface

// File: rtl/mreq_pkt_tx.sv
// mreq_pkt_tx
//   Serialises one MREQ into a byte packet for the UART/FT Tx FIFO:
//     START, OP, WCOUNT, ADDR_BYTES address bytes (LSB first), header CRC8,
//   and for writes the payload: N words of 1/2/4 bytes each, LSB byte first.
//   Optional feature macro MREQ_PKT_TX_DCRC_EN: writes append a CRC8 over the
//   payload bytes only. Without it a write ends on its last payload byte.
// Ports
//   clk  : clock, rising edge
//   rst  : synchronous reset, active high; abandons any packet in flight
//   bus  : mreq_pkt_tx_if.slave (byte stream out, MREQ request in, payload words in)
// Parameters
//   ADDR_BYTES    : address bytes sent (1..4)
//   WORD_BYTES    : payload word width in bytes (1..4); bytes above it read as 0
//   CMD_TX_START  : START byte value
//   CMD_OP_MREAD  : OP[2:0] code for reads
//   CMD_OP_MWRITE : OP[2:0] code for writes
//   CRC_POLY      : CRC8 polynomial (MSB first, init 0, no final xor)
module mreq_pkt_tx #(
  parameter int         ADDR_BYTES    = 4,
  parameter int         WORD_BYTES    = 4,
  parameter logic [7:0] CMD_TX_START  = 8'hA5,
  parameter logic [2:0] CMD_OP_MREAD  = 3'd1,
  parameter logic [2:0] CMD_OP_MWRITE = 3'd2,
  parameter logic [7:0] CRC_POLY      = 8'h07
) (
  input  logic         clk,
  input  logic         rst,
  mreq_pkt_tx_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_OP,
    S_WCOUNT,
    S_ADDR,
    S_HCRC,
    S_PAYLOAD
`ifdef MREQ_PKT_TX_DCRC_EN
    , S_DCRC
`endif
  } state_t;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

  state_t                  state_q, state_d;
  logic                    wr_q, wr_d;
  logic [1:0]              wsize_q, wsize_d;
  logic                    aincr_q, aincr_d;
  logic [7:0]              size_q, size_d;
  logic [8*ADDR_BYTES-1:0] addr_q, addr_d;
  logic [1:0]              byte_idx_q, byte_idx_d;   // address byte in ADDR, word byte in PAYLOAD
  logic [8:0]              words_left_q, words_left_d;
  logic [8*WORD_BYTES-1:0] buf_q, buf_d;
  logic                    buf_valid_q, buf_valid_d;
  logic [7:0]              hcrc_q, hcrc_d;
`ifdef MREQ_PKT_TX_DCRC_EN
  logic [7:0]              dcrc_q, dcrc_d;
`endif

  logic [31:0] addr_ext;
  logic [31:0] buf_ext;
  logic [1:0]  last_byte_idx;
  logic [7:0]  op_byte;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        ack;
  logic        wdata_ready;
  logic        mreq_ready;

  // Zero-extended views so byte selection never runs past the real width.
  always_comb begin
    addr_ext = '0;
    addr_ext[8*ADDR_BYTES-1:0] = addr_q;
    buf_ext = '0;
    buf_ext[8*WORD_BYTES-1:0] = buf_q;
  end

  // wsize 3 is reserved and transmitted like 4-byte words.
  always_comb begin
    case (wsize_q)
      2'd0:    last_byte_idx = 2'd0;
      2'd1:    last_byte_idx = 2'd1;
      default: last_byte_idx = 2'd3;
    endcase
  end

  assign op_byte = {2'b00, wsize_q, aincr_q, (wr_q ? CMD_OP_MWRITE : CMD_OP_MREAD)};

  // Byte presented to the sink depends only on registered state, so it holds
  // steady while the sink stalls.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state_q)
      S_START:  begin tx_valid = 1'b1; tx_data = CMD_TX_START; end
      S_OP:     begin tx_valid = 1'b1; tx_data = op_byte; end
      S_WCOUNT: begin tx_valid = 1'b1; tx_data = size_q; end
      S_ADDR:   begin tx_valid = 1'b1; tx_data = addr_ext[{byte_idx_q, 3'b000} +: 8]; end
      S_HCRC:   begin tx_valid = 1'b1; tx_data = hcrc_q; end
      S_PAYLOAD: begin
        tx_valid = buf_valid_q;
        tx_data  = buf_valid_q ? buf_ext[{byte_idx_q, 3'b000} +: 8] : 8'h00;
      end
`ifdef MREQ_PKT_TX_DCRC_EN
      S_DCRC:   begin tx_valid = 1'b1; tx_data = dcrc_q; end
`endif
      default:  begin tx_valid = 1'b0; tx_data = 8'h00; end
    endcase
  end

  assign ack = tx_valid && bus.i_tx_ready;

  // Built only from registers: the sink's ready never reaches o_wdata_ready.
  assign wdata_ready = (state_q == S_PAYLOAD) && !buf_valid_q && (words_left_q != 9'd0);

  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    wsize_d      = wsize_q;
    aincr_d      = aincr_q;
    size_d       = size_q;
    addr_d       = addr_q;
    byte_idx_d   = byte_idx_q;
    words_left_d = words_left_q;
    buf_d        = buf_q;
    buf_valid_d  = buf_valid_q;
    hcrc_d       = hcrc_q;
`ifdef MREQ_PKT_TX_DCRC_EN
    dcrc_d       = dcrc_q;
`endif
    mreq_ready   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.i_mreq_valid) begin
          wr_d         = bus.i_mreq_wr;
          wsize_d      = bus.i_mreq_wsize;
          aincr_d      = bus.i_mreq_aincr;
          size_d       = bus.i_mreq_size;
          addr_d       = bus.i_mreq_addr;
          words_left_d = (bus.i_mreq_size == 8'd0) ? 9'd256 : {1'b0, bus.i_mreq_size};
          byte_idx_d   = 2'd0;
          buf_valid_d  = 1'b0;
          hcrc_d       = 8'h00;
`ifdef MREQ_PKT_TX_DCRC_EN
          dcrc_d       = 8'h00;
`endif
          state_d      = S_START;
        end
      end
      S_START: if (ack) begin hcrc_d = crc8_byte(hcrc_q, tx_data); state_d = S_OP; end
      S_OP:    if (ack) begin hcrc_d = crc8_byte(hcrc_q, tx_data); state_d = S_WCOUNT; end
      S_WCOUNT: if (ack) begin hcrc_d = crc8_byte(hcrc_q, tx_data); state_d = S_ADDR; end
      S_ADDR: begin
        if (ack) begin
          hcrc_d = crc8_byte(hcrc_q, tx_data);
          if (byte_idx_q == 2'(ADDR_BYTES - 1)) begin
            byte_idx_d = 2'd0;
            state_d    = S_HCRC;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      S_HCRC: begin
        if (ack) begin
          if (wr_q) begin
            state_d = S_PAYLOAD;
          end else begin
            state_d    = S_IDLE;
            mreq_ready = 1'b1;
          end
        end
      end
      S_PAYLOAD: begin
        // Accept and ack are exclusive: one needs the buffer empty, the other full.
        if (wdata_ready && bus.i_wdata_valid) begin
          buf_d        = bus.i_wdata;
          buf_valid_d  = 1'b1;
          words_left_d = words_left_q - 9'd1;
        end
        if (ack) begin
`ifdef MREQ_PKT_TX_DCRC_EN
          dcrc_d = crc8_byte(dcrc_q, tx_data);
`endif
          if (byte_idx_q == last_byte_idx) begin
            byte_idx_d  = 2'd0;
            buf_valid_d = 1'b0;
            // words_left already counts the word being drained.
            if (words_left_q == 9'd0) begin
`ifdef MREQ_PKT_TX_DCRC_EN
              state_d = S_DCRC;
`else
              state_d    = S_IDLE;
              mreq_ready = 1'b1;
`endif
            end
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
`ifdef MREQ_PKT_TX_DCRC_EN
      S_DCRC: begin
        if (ack) begin
          state_d    = S_IDLE;
          mreq_ready = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_q         <= 1'b0;
      wsize_q      <= 2'd0;
      aincr_q      <= 1'b0;
      size_q       <= 8'd0;
      addr_q       <= '0;
      byte_idx_q   <= 2'd0;
      words_left_q <= 9'd0;
      buf_q        <= '0;
      buf_valid_q  <= 1'b0;
      hcrc_q       <= 8'h00;
`ifdef MREQ_PKT_TX_DCRC_EN
      dcrc_q       <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      wsize_q      <= wsize_d;
      aincr_q      <= aincr_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      byte_idx_q   <= byte_idx_d;
      words_left_q <= words_left_d;
      buf_q        <= buf_d;
      buf_valid_q  <= buf_valid_d;
      hcrc_q       <= hcrc_d;
`ifdef MREQ_PKT_TX_DCRC_EN
      dcrc_q       <= dcrc_d;
`endif
    end
  end

  assign bus.o_tx_data     = tx_data;
  assign bus.o_tx_valid    = tx_valid;
  assign bus.o_mreq_ready  = mreq_ready;
  assign bus.o_wdata_ready = wdata_ready;

endmodule

// File: tb/tb_mreq_pkt_tx.sv
// tb_mreq_pkt_tx
//   Drives mreq_pkt_tx (ADDR_BYTES=4, WORD_BYTES=4) with directed and random
//   requests and checks every transmitted byte against a packet built from the
//   protocol rules (header layout, CRC8, payload byte order).
module tb_mreq_pkt_tx;
  localparam int         AB       = 4;
  localparam int         WB       = 4;
  localparam logic [7:0] TB_START = 8'hA5;
  localparam logic [2:0] TB_MREAD = 3'd1;
  localparam logic [2:0] TB_MWRITE = 3'd2;
  localparam logic [7:0] TB_POLY  = 8'h07;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mreq_pkt_tx_if #(.ADDR_BYTES(AB), .WORD_BYTES(WB)) bus ();

  mreq_pkt_tx #(
    .ADDR_BYTES(AB), .WORD_BYTES(WB), .CMD_TX_START(TB_START),
    .CMD_OP_MREAD(TB_MREAD), .CMD_OP_MWRITE(TB_MWRITE), .CRC_POLY(TB_POLY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference CRC8: bitwise long division, MSB first, init supplied by caller.
  function automatic logic [7:0] ref_crc8(input logic [7:0] crc, input logic [7:0] d);
    logic [8:0] r;
    r = {1'b0, crc ^ d};
    for (int b = 0; b < 8; b++) begin
      r = r << 1;
      if (r[8]) r = r ^ {1'b1, TB_POLY};
    end
    return r[7:0];
  endfunction

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_tx_valid"},    32'(bus.o_tx_valid),    32'd0);
    chk({tag, "_tx_data"},     32'(bus.o_tx_data),     32'd0);
    chk({tag, "_mreq_ready"},  32'(bus.o_mreq_ready),  32'd0);
    chk({tag, "_wdata_ready"}, 32'(bus.o_wdata_ready), 32'd0);
  endtask

  // Sends one request and checks the whole packet. Called just after a negedge.
  //   rnd_ready  : sink ready random 50% instead of always 1
  //   stall_word : payload word index at which i_wdata_valid is held low 10 cycles (-1 none)
  //   abort_at   : return (without finishing) once this many bytes were acked (-1 none)
  //   fixed_words: use the two fixed payload words 0xAABB1122, 0xCCDD3344
  task automatic run_pkt(input bit wr, input logic [1:0] wsize, input bit aincr,
                         input logic [7:0] size, input logic [31:0] addr,
                         input bit rnd_ready, input int stall_word, input int abort_at,
                         input bit fixed_words);
    logic [7:0]  exp_q[$];
    logic [31:0] words[$];
    logic [7:0]  crc;
    logic [31:0] w;
    int nwords, bpw, bi, widx, stall_cnt;
    bit done, in_stall, pv, pr, rdy;
    logic [7:0] pd;

    nwords = wr ? ((size == 8'd0) ? 256 : int'(size)) : 0;
    bpw    = (wsize == 2'd0) ? 1 : (wsize == 2'd1) ? 2 : 4;
    for (int i = 0; i < nwords; i++) begin
      if (fixed_words) w = (i == 0) ? 32'hAABB1122 : 32'hCCDD3344;
      else             w = $urandom;
      words.push_back(w);
    end

    // Expected packet from the protocol rules.
    exp_q.push_back(TB_START);
    exp_q.push_back({2'b00, wsize, aincr, (wr ? TB_MWRITE : TB_MREAD)});
    exp_q.push_back(size);
    for (int k = 0; k < AB; k++) exp_q.push_back(addr[8*k +: 8]);
    crc = 8'h00;
    foreach (exp_q[i]) crc = ref_crc8(crc, exp_q[i]);
    exp_q.push_back(crc);
    crc = 8'h00;
    for (int i = 0; i < nwords; i++) begin
      for (int b = 0; b < bpw; b++) begin
        exp_q.push_back(words[i][8*b +: 8]);
        crc = ref_crc8(crc, words[i][8*b +: 8]);
      end
    end
`ifdef MREQ_PKT_TX_DCRC_EN
    if (wr) exp_q.push_back(crc);
`endif

    bus.i_mreq_wr    = wr;
    bus.i_mreq_wsize = wsize;
    bus.i_mreq_aincr = aincr;
    bus.i_mreq_size  = size;
    bus.i_mreq_addr  = addr;
    bus.i_mreq_valid = 1'b1;

    bi = 0; widx = 0; stall_cnt = 0; done = 0; pv = 0; pr = 0; pd = 8'h00;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      @(negedge clk);
      if (abort_at >= 0 && bi == abort_at) return;
      rdy = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      in_stall = (stall_word >= 0) && (widx == stall_word) && (stall_cnt < 10);
      bus.i_tx_ready    = rdy;
      bus.i_wdata_valid = !in_stall && (widx < nwords);
      bus.i_wdata       = (widx < nwords) ? words[widx] : 32'h0;
      #1;
      if (in_stall) begin
        stall_cnt++;
        if (stall_cnt > 5) chk("stall_tx_valid", 32'(bus.o_tx_valid), 32'd0);
      end
      if (pv && !pr) begin
        chk("hold_tx_valid", 32'(bus.o_tx_valid), 32'd1);
        chk("hold_tx_data",  32'(bus.o_tx_data),  32'(pd));
      end
      if (bus.o_tx_valid && rdy) begin
        if (bi < exp_q.size()) chk("tx_byte", 32'(bus.o_tx_data), 32'(exp_q[bi]));
        else                   chk("tx_overrun", 32'(bus.o_tx_valid), 32'd0);
        bi++;
      end
      if (bus.o_wdata_ready && bus.i_wdata_valid) widx++;
      if (bus.o_mreq_ready) begin
        chk("mreq_ready_byte_count", 32'(bi), 32'(exp_q.size()));
        done = 1;
      end
      pv = bus.o_tx_valid; pr = rdy; pd = bus.o_tx_data;
    end
    if (!done) chk("timeout_mreq_ready", 32'(done), 32'd1);
    chk("wdata_accepts", 32'(widx), 32'(nwords));
    $display("pkt wr=%0d wsize=%0d size=%0d addr=0x%08h bytes=%0d/%0d words=%0d",
             wr, wsize, size, addr, bi, exp_q.size(), widx);

    // One idle cycle follows every packet; the request is dropped now.
    @(negedge clk);
    bus.i_mreq_valid  = 1'b0;
    bus.i_wdata_valid = 1'b0;
    #1;
    chk("idle_gap_tx_valid",   32'(bus.o_tx_valid),   32'd0);
    chk("idle_gap_mreq_ready", 32'(bus.o_mreq_ready), 32'd0);
  endtask

  initial begin
    bus.i_tx_ready    = 1'b0;
    bus.i_mreq_valid  = 1'b0;
    bus.i_mreq_wr     = 1'b0;
    bus.i_mreq_wsize  = 2'd0;
    bus.i_mreq_aincr  = 1'b0;
    bus.i_mreq_size   = 8'd0;
    bus.i_mreq_addr   = '0;
    bus.i_wdata       = '0;
    bus.i_wdata_valid = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;

    // T1: read, 4 address bytes, always ready
    run_pkt(1'b0, 2'd2, 1'b1, 8'd3, 32'h12345678, 1'b0, -1, -1, 1'b0);
    // T2: write, 2-byte words, fixed payload
    run_pkt(1'b1, 2'd1, 1'b0, 8'd2, $urandom, 1'b0, -1, -1, 1'b1);
    // T3: same two packets with a random-ready sink
    run_pkt(1'b0, 2'd2, 1'b1, 8'd3, 32'h12345678, 1'b1, -1, -1, 1'b0);
    run_pkt(1'b1, 2'd1, 1'b0, 8'd2, $urandom, 1'b1, -1, -1, 1'b1);
    // T4: size 0 means 256 single-byte words
    run_pkt(1'b1, 2'd0, 1'($urandom_range(0, 1)), 8'd0, $urandom, 1'b0, -1, -1, 1'b0);
    // T5: payload source stalls 10 cycles mid-packet
    run_pkt(1'b1, 2'd2, 1'b0, 8'd6, $urandom, 1'b0, 3, -1, 1'b0);
    // Reserved wsize transmits 4-byte words
    run_pkt(1'b1, 2'd3, 1'b1, 8'd3, $urandom, 1'b1, -1, -1, 1'b0);
    // Random mix
    for (int n = 0; n < 8; n++) begin
      run_pkt(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              8'($urandom_range(1, 9)), $urandom, 1'b1, -1, -1, 1'b0);
    end

    // T6: reset while the second address byte is on the bus
    run_pkt(1'b1, 2'd2, 1'b1, 8'd4, $urandom, 1'b1, -1, 4, 1'b0);
    rst               = 1'b1;
    bus.i_mreq_valid  = 1'b0;
    bus.i_wdata_valid = 1'b0;
    bus.i_tx_ready    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_outputs_zero("after_rst");
    run_pkt(1'b0, 2'd2, 1'b1, 8'd3, 32'h12345678, 1'b0, -1, -1, 1'b0);
    run_pkt(1'b1, 2'd1, 1'b0, 8'd2, $urandom, 1'b1, -1, -1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
